multi_cycle_control: RTL

//  Multi-cycle CPU control FSM; sits directly upstream of the ALU.
//  - Sequences each instruction through IF/ID/EXE/MEM/WB states.
//  - Drives the ALU op code, the datapath mux selects and the write enables.
//  - Takes zero/sign from the ALU for branch resolution.

---
 rtl/multi_cycle_control_pkg.sv | 64 ++++++
 rtl/alu_op_decode.sv | 41 ++++
 rtl/multi_cycle_control.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared state, opcode, ALU-op and mux-select codes for the multi-cycle control FSM.
package multi_cycle_control_pkg;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_ORI   = 6'b010010;
   localparam logic [5:0] OP_XORI  = 6'b010011;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLTI  = 6'b100110;
   localparam logic [5:0] OP_SLT   = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b110;
   localparam logic [2:0] ALU_XOR = 3'b111;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   function automatic logic is_rtype(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_SLL, OP_SLT};
   endfunction

   function automatic logic is_imm_op(input logic [5:0] op);
      return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
   endfunction

   function automatic logic is_branch(input logic [5:0] op);
      return op inside {OP_BEQ, OP_BNE, OP_BLTZ};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode -> ALU operation, operand selects and immediate extension.
module alu_op_decode
   import multi_cycle_control_pkg::*;
(
   input  logic [5:0] i_opcode,
   output logic [2:0] o_alu_op,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_ext_sel
);

   always_comb begin
      o_alu_op    = ALU_ADD;
      o_alu_src_a = 1'b0;
      o_alu_src_b = is_imm_op(i_opcode) || (i_opcode == OP_LW) || (i_opcode == OP_SW);
      o_ext_sel   = 1'b1;
      case (i_opcode)
         OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: o_alu_op = ALU_SUB;
         OP_SLL: begin
            o_alu_op    = ALU_SLL;
            o_alu_src_a = 1'b1;
         end
         OP_ORI: begin
            o_alu_op  = ALU_OR;
            o_ext_sel = 1'b0;
         end
         OP_AND:  o_alu_op = ALU_AND;
         OP_ANDI: begin
            o_alu_op  = ALU_AND;
            o_ext_sel = 1'b0;
         end
         OP_SLT, OP_SLTI: o_alu_op = ALU_SLT;
         OP_XORI: begin
            o_alu_op  = ALU_XOR;
            o_ext_sel = 1'b0;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and decodes datapath controls.
// Outputs are combinational from state/opcode/flags; halt parks the FSM in ID until Reset.
module multi_cycle_control
   import multi_cycle_control_pkg::*;
#(
   parameter int OPW = 6,
   parameter int STW = 3
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           sign,
   output logic [STW-1:0] state,
   output logic           PCWre,
   output logic           IRWre,
   output logic           InsMemRW,
   output logic           ALUSrcA,
   output logic           ALUSrcB,
   output logic [2:0]     ALUOp,
   output logic           ExtSel,
   output logic           mRD,
   output logic           mWR,
   output logic           DBDataSrc,
   output logic           RegWre,
   output logic           WrRegDSrc,
   output logic [1:0]     RegDst,
   output logic [1:0]     PCSrc
);

   state_t     r_state, w_next;
   logic       r_halt, w_halt_set;
   logic [2:0] w_dec_alu_op;
   logic       w_dec_src_a, w_dec_src_b, w_dec_ext;
   logic       w_is_alu, w_is_ls, w_is_br, w_is_halt, w_taken;

   alu_op_decode u_alu_op_decode (
      .i_opcode    (opcode),
      .o_alu_op    (w_dec_alu_op),
      .o_alu_src_a (w_dec_src_a),
      .o_alu_src_b (w_dec_src_b),
      .o_ext_sel   (w_dec_ext)
   );

   assign w_is_alu  = is_rtype(opcode) || is_imm_op(opcode);
   assign w_is_ls   = (opcode == OP_LW) || (opcode == OP_SW);
   assign w_is_br   = is_branch(opcode);
   assign w_is_halt = r_halt || (opcode == OP_HALT);
   assign w_taken   = ((opcode == OP_BEQ)  &&  zero) ||
                      ((opcode == OP_BNE)  && !zero) ||
                      ((opcode == OP_BLTZ) &&  sign);
   assign state     = r_state;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_state <= S_IF;
         r_halt  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_halt_set) r_halt <= 1'b1;
      end
   end

   always_comb begin
      w_next     = S_IF;
      w_halt_set = 1'b0;
      PCWre      = 1'b0;
      IRWre      = 1'b0;
      InsMemRW   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 1'b0;
      ALUOp      = ALU_ADD;
      ExtSel     = 1'b0;
      mRD        = 1'b0;
      mWR        = 1'b0;
      DBDataSrc  = 1'b0;
      RegWre     = 1'b0;
      WrRegDSrc  = 1'b0;
      RegDst     = RD_RA;
      PCSrc      = PC_NEXT;
      // Opcode is only meaningful once IR has latched it, so IF keeps the ALU at add.
      if (r_state != S_IF) begin
         ALUOp   = w_dec_alu_op;
         ALUSrcA = w_dec_src_a;
         ALUSrcB = w_dec_src_b;
         ExtSel  = w_dec_ext;
      end
      case (r_state)
         S_IF: begin
            w_next   = S_ID;
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
         end
         S_ID: begin
            if (w_is_halt) begin
               w_next     = S_ID;
               w_halt_set = 1'b1;
            end else if (w_is_alu) begin
               w_next = S_EXE_AL;
            end else if (w_is_ls) begin
               w_next = S_EXE_LS;
            end else if (w_is_br) begin
               w_next = S_EXE_BR;
            end else begin
               // Jumps and unknown opcodes retire here.
               PCWre = 1'b1;
               case (opcode)
                  OP_J:  PCSrc = PC_JUMP;
                  OP_JR: PCSrc = PC_RS;
                  OP_JAL: begin
                     PCSrc     = PC_JUMP;
                     RegWre    = 1'b1;
                     RegDst    = RD_RA;
                     WrRegDSrc = 1'b0;
                  end
                  default: PCSrc = PC_NEXT;
               endcase
            end
         end
         S_EXE_AL: w_next = S_WB_AL;
         S_WB_AL: begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = is_rtype(opcode) ? RD_RD : RD_RT;
         end
         S_EXE_LS: w_next = S_MEM;
         S_MEM: begin
            if (opcode == OP_LW) begin
               w_next = S_WB_LD;
               mRD    = 1'b1;
            end else begin
               mWR   = 1'b1;
               PCWre = 1'b1;
            end
         end
         S_WB_LD: begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            DBDataSrc = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = RD_RT;
         end
         S_EXE_BR: begin
            PCWre = 1'b1;
            PCSrc = w_taken ? PC_BRANCH : PC_NEXT;
         end
         default: w_next = S_IF;
      endcase
   end

endmodule
